audio_smpl_queue: RTL and testbench

Stereo sample history buffer and sequencer that feeds the FIR filter bank. On every new stereo sample it stores the sample in a circular buffer. Once the buffer holds a full filter window, it streams the most recent `TAPS` samples, oldest first, one per clock, while holding `sequencing` high. It sits between the audio sample source and the FIR filters and drives their `sequencing`, `lft_in` and `rght_in` inputs.

---
 rtl/audio_smpl_queue.sv | 62 ++++++
 tb/tb_audio_smpl_queue.sv | 134 +++++++++++++
 2 files changed

// File: rtl/audio_smpl_queue.sv
// audio_smpl_queue: stereo sample history buffer that streams the last TAPS samples, oldest first, after each new sample.
module audio_smpl_queue #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               ovr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] taps_c = CW'(TAPS);
  localparam logic [CW-1:0] last_c = CW'(TAPS - 1);
  localparam logic [AW-1:0] back_c = AW'(TAPS - 1);
  typedef enum logic [1:0] {IDLE, PRIME, SEQ} state_t;
  state_t state, nxt;
  logic [AW-1:0] new_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt, tap;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data;
  logic acc;
  assign acc = wrt_smpl && state == IDLE;
  always_comb begin
    cnt_nxt = (acc && cnt != taps_c) ? cnt + CW'(1) : cnt;
    nxt = state;
    if (state == IDLE) nxt = (acc && cnt_nxt == taps_c) ? PRIME : IDLE;
    else if (state == PRIME) nxt = SEQ;
    else nxt = (tap == last_c) ? IDLE : SEQ;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      new_ptr <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      tap     <= '0;
      ovr     <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      ovr   <= ovr | (wrt_smpl && state != IDLE);
      tap   <= (state == PRIME) ? '0 : (state == SEQ) ? tap + CW'(1) : tap;
      if (acc) new_ptr <= new_ptr + AW'(1);
      if (acc && cnt_nxt == taps_c) rd_ptr <= new_ptr - back_c;
      else if (state != IDLE) rd_ptr <= rd_ptr + AW'(1);
    end
  end
  // Reads run every cycle; only the ones issued from PRIME/SEQ are ever shown.
  always_ff @(posedge clk) begin
    if (acc) mem[new_ptr] <= {lft_smpl, rght_smpl};
    rd_data <= mem[rd_ptr];
  end
  assign sequencing = state == SEQ;
  assign lft_out    = sequencing ? rd_data[31:16] : '0;
  assign rght_out   = sequencing ? rd_data[15:0]  : '0;
endmodule

// File: tb/tb_audio_smpl_queue.sv
// tb_audio_smpl_queue: randomized scoreboard bench for audio_smpl_queue, reduced DEPTH/TAPS.
module tb_audio_smpl_queue;
  localparam int DEPTH = 16;
  localparam int TAPS  = 13;
  logic clk = 0, rst_n = 0, wrt_smpl = 0;
  logic signed [15:0] lft_smpl = 0, rght_smpl = 0;
  logic sequencing, ovr;
  logic signed [15:0] lft_out, rght_out;
  audio_smpl_queue #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
    .sequencing(sequencing), .lft_out(lft_out), .rght_out(rght_out), .ovr(ovr)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] hist[$], exp_q[$];
  int start_q[$];
  int last_e = -1000;
  bit ovr_m = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // Reference: a sample is accepted if no burst is pending; a full window emits the last TAPS samples.
  task automatic wr(input logic [15:0] l, input logic [15:0] r);
    int e;
    @(negedge clk);
    e = cyc + 1;
    wrt_smpl = 1; lft_smpl = l; rght_smpl = r;
    if (e >= last_e + TAPS + 2) begin
      hist.push_back({l, r});
      if (hist.size() > TAPS) void'(hist.pop_front());
      if (hist.size() == TAPS) begin
        foreach (hist[i]) exp_q.push_back(hist[i]);
        start_q.push_back(e + 1);
        last_e = e;
      end
    end else ovr_m = 1;
    @(negedge clk);
    wrt_smpl = 0; lft_smpl = 16'($urandom); rght_smpl = 16'($urandom);
  endtask
  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_reset();
    hist.delete(); exp_q.delete(); start_q.delete();
    last_e = -1000; ovr_m = 0;
  endtask
  int run = 0;
  always @(negedge clk) begin
    logic [31:0] s;
    if (!rst_n) begin
      chk("rst_seq", int'(sequencing), 0);
      chk("rst_lft", int'(lft_out), 0);
      chk("rst_rght", int'(rght_out), 0);
      chk("rst_ovr", int'(ovr), 0);
      run = 0;
    end else if (sequencing) begin
      if (run == 0) begin
        if (start_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL burst_start: unexpected burst at cycle %0d", cyc);
        end else chk("burst_start", cyc, start_q.pop_front());
      end
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tap: unexpected tap lft=%0d rght=%0d at cycle %0d", lft_out, rght_out, cyc);
      end else begin
        s = exp_q.pop_front();
        chk("tap_lft", int'(lft_out), int'($signed(s[31:16])));
        chk("tap_rght", int'(rght_out), int'($signed(s[15:0])));
      end
      run++;
    end else begin
      if (run != 0) chk("burst_len", run, TAPS);
      run = 0;
      chk("idle_lft", int'(lft_out), 0);
      chk("idle_rght", int'(rght_out), 0);
    end
  end
  initial begin
    int k;
    repeat (5) begin
      @(negedge clk);
      wrt_smpl = 1'($urandom); lft_smpl = 16'($urandom); rght_smpl = 16'($urandom);
    end
    @(negedge clk);
    wrt_smpl = 0;
    #2 rst_n = 1;
    gap(5);
    for (k = 0; k < 60; k++) begin
      wr(16'(k), 16'(-k));
      gap(TAPS + (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3)));
    end
    chk("no_ovr_yet", int'(ovr), 0);
    wr(16'(k), 16'(-k)); k++;
    gap(9);
    wr(16'h7fff, 16'h7fff);
    chk("ovr_set", int'(ovr), 1);
    gap(TAPS);
    wr(16'(k), 16'(-k)); k++;
    gap(TAPS + 2);
    chk("ovr_sticky", int'(ovr), 1);
    wr(16'(k), 16'(-k)); k++;
    gap(5);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_seq", int'(sequencing), 0);
    chk("mid_rst_lft", int'(lft_out), 0);
    chk("mid_rst_ovr", int'(ovr), 0);
    gap(2);
    @(negedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < TAPS; i++) begin
      wr(16'($urandom), 16'($urandom));
      gap(TAPS + $urandom_range(0, 2));
    end
    for (int i = 0; i < 80; i++) begin
      wr(16'($urandom), 16'($urandom));
      gap($urandom_range(0, TAPS + 3));
    end
    gap(TAPS + 5);
    chk("final_ovr", int'(ovr), int'(ovr_m));
    chk("taps_drained", exp_q.size(), 0);
    chk("bursts_drained", start_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
